// File: rtl/tpu_pkg.sv
// Shared types and default sizing for the MAC array control path.
package tpu_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Default array dimension and vector-count/address width.
    localparam int TPU_N  = 4;
    localparam int TPU_VW = 8;

endpackage

// File: rtl/mac_array_ctrl_skew_shreg.sv
// skew_shreg: N-bit tapped delay line. Tap r is din delayed r+1 cycles,
// which gives each array row its activation-valid one cycle after the row above.
module skew_shreg #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din,
    output logic [N-1:0] dout
);

    logic [N-1:0] vld_pipe;

    // Free-running shift; never stalled, so trailing bits drain on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[N-2:0], din};
        end
    end

    assign dout = vld_pipe;

endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: job sequencer for an N x N systolic MAC array.
// Loads weights bottom row first, streams num_vec activation vectors with
// row skew, then collects num_vec results before pulsing done.
// Optional feature: define MAC_ARRAY_CTRL_PERF_EN to add a 32-bit busy-cycle
// counter on output perf_cycles.
module mac_array_ctrl
    import tpu_pkg::*;
#(
    parameter int N  = TPU_N,
    parameter int VW = TPU_VW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [VW-1:0]        num_vec,
    output logic                 busy,
    output logic                 done,
    output logic                 w_rd_en,
    output logic [$clog2(N)-1:0] w_rd_addr,
    output logic                 init_win,
    output logic                 a_rd_en,
    output logic [VW-1:0]        a_rd_addr,
    output logic [N-1:0]         dv_ain,
    input  logic                 res_valid,
    output logic                 res_wr_en,
    output logic [VW-1:0]        res_wr_addr
`ifdef MAC_ARRAY_CTRL_PERF_EN
   ,output logic [31:0]          perf_cycles
`endif
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] W_ONE = AW'(1);
    localparam logic [AW-1:0] W_TOP = AW'(N - 1);
    localparam logic [VW-1:0] V_ONE = VW'(1);

    state_t        state, state_nxt;
    logic [AW-1:0] w_cnt;
    logic [VW-1:0] a_cnt;
    logic [VW-1:0] res_cnt;
    logic [VW-1:0] res_cnt_nxt;
    logic [VW-1:0] num_vec_q;
    logic          start_acc;
    logic          in_cap;
    logic          wr_fire;

    // A zero-length job is never accepted, so counters can compare against num_vec_q - 1.
    assign start_acc   = (state == ST_IDLE) && start && (num_vec != '0);
    assign in_cap      = (state == ST_STREAM) || (state == ST_DRAIN);
    // Extra results past the job length are dropped so res_cnt never exceeds num_vec_q.
    assign wr_fire     = res_valid && in_cap && (res_cnt < num_vec_q);
    assign res_cnt_nxt = wr_fire ? (res_cnt + V_ONE) : res_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        w_rd_en   = 1'b0;
        a_rd_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start_acc) state_nxt = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                w_rd_en = 1'b1;
                if (w_cnt == '0) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                a_rd_en = 1'b1;
                if (a_cnt == num_vec_q - V_ONE) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave as soon as the last result lands, including one written this cycle.
                if (res_cnt_nxt == num_vec_q) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Job counters: reloaded on an accepted start, each advances only in its own phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_vec_q <= '0;
            w_cnt     <= '0;
            a_cnt     <= '0;
            res_cnt   <= '0;
        end else if (start_acc) begin
            num_vec_q <= num_vec;
            w_cnt     <= W_TOP;
            a_cnt     <= '0;
            res_cnt   <= '0;
        end else begin
            if (w_rd_en && (w_cnt != '0)) w_cnt <= w_cnt - W_ONE;
            if (a_rd_en && (a_cnt != num_vec_q - V_ONE)) a_cnt <= a_cnt + V_ONE;
            res_cnt <= res_cnt_nxt;
        end
    end

    // Weight data arrives one cycle after the read, so the shift enable trails w_rd_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_win <= 1'b0;
        end else begin
            init_win <= w_rd_en;
        end
    end

    // Addresses are forced to zero whenever their strobe is low.
    assign w_rd_addr   = w_rd_en ? w_cnt : '0;
    assign a_rd_addr   = a_rd_en ? a_cnt : '0;
    assign res_wr_en   = wr_fire;
    assign res_wr_addr = wr_fire ? res_cnt : '0;

    skew_shreg #(.N(N)) u_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (a_rd_en),
        .dout  (dv_ain)
    );

`ifdef MAC_ARRAY_CTRL_PERF_EN
    // Busy-cycle count for the current job; cleared by an accepted start, frozen in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (start_acc) begin
            perf_cycles <= '0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl at N=4, VW=8. Build with
// MAC_ARRAY_CTRL_PERF_EN defined to also exercise perf_cycles.
module tb_mac_array_ctrl;

    localparam int N  = 4;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [VW-1:0] num_vec;
    logic          busy, done, w_rd_en, init_win, a_rd_en, res_valid, res_wr_en;
    logic [1:0]    w_rd_addr;
    logic [VW-1:0] a_rd_addr, res_wr_addr;
    logic [N-1:0]  dv_ain;
`ifdef MAC_ARRAY_CTRL_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mac_array_ctrl #(.N(N), .VW(VW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_vec     (num_vec),
        .busy        (busy),
        .done        (done),
        .w_rd_en     (w_rd_en),
        .w_rd_addr   (w_rd_addr),
        .init_win    (init_win),
        .a_rd_en     (a_rd_en),
        .a_rd_addr   (a_rd_addr),
        .dv_ain      (dv_ain),
        .res_valid   (res_valid),
        .res_wr_en   (res_wr_en),
        .res_wr_addr (res_wr_addr)
`ifdef MAC_ARRAY_CTRL_PERF_EN
       ,.perf_cycles (perf_cycles)
`endif
    );

    typedef struct {
        logic          start;
        logic [VW-1:0] nv;
        logic          rv;
        logic          busy;
        logic          done;
        logic          wen;
        logic [1:0]    waddr;
        logic          iw;
        logic          aen;
        logic [VW-1:0] aaddr;
        logic [N-1:0]  dv;
        logic          ren;
        logic [VW-1:0] raddr;
    } vec_t;

    vec_t tv [15];

    function automatic vec_t mk(int s, int nv, int rv, int b, int d, int we, int wa,
                                int iw, int ae, int aa, int dv, int re, int ra);
        vec_t v;
        v.start = s[0];  v.nv = nv[VW-1:0]; v.rv = rv[0];
        v.busy  = b[0];  v.done = d[0];     v.wen = we[0]; v.waddr = wa[1:0];
        v.iw    = iw[0]; v.aen = ae[0];     v.aaddr = aa[VW-1:0];
        v.dv    = dv[N-1:0]; v.ren = re[0]; v.raddr = ra[VW-1:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int  na, nw, nd, la, lw, nbusy;
    bit  fin;

    initial begin
        // Job: num_vec=3. Extra start(nv=5) mid-STREAM must be ignored; res_valid
        // in IDLE/LOAD_W/DONE ignored; results arrive at three DRAIN cycles.
        //              st nv rv  by dn we wa iw ae aa dv      re ra
        tv[0]  = mk(1, 3, 1,  0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        tv[1]  = mk(0, 0, 0,  1, 0, 1, 3, 0, 0, 0, 4'b0000, 0, 0);
        tv[2]  = mk(0, 0, 1,  1, 0, 1, 2, 1, 0, 0, 4'b0000, 0, 0);
        tv[3]  = mk(0, 0, 0,  1, 0, 1, 1, 1, 0, 0, 4'b0000, 0, 0);
        tv[4]  = mk(0, 0, 0,  1, 0, 1, 0, 1, 0, 0, 4'b0000, 0, 0);
        tv[5]  = mk(0, 0, 0,  1, 0, 0, 0, 1, 1, 0, 4'b0000, 0, 0);
        tv[6]  = mk(1, 5, 0,  1, 0, 0, 0, 0, 1, 1, 4'b0001, 0, 0);
        tv[7]  = mk(0, 0, 0,  1, 0, 0, 0, 0, 1, 2, 4'b0011, 0, 0);
        tv[8]  = mk(0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 4'b0111, 0, 0);
        tv[9]  = mk(0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 4'b1110, 1, 0);
        tv[10] = mk(0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 0);
        tv[11] = mk(0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 4'b1000, 1, 1);
        tv[12] = mk(0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 2);
        tv[13] = mk(0, 0, 1,  1, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        tv[14] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);

        // Reset state, with inputs active during reset.
        rst_n = 1'b0; start = 1'b1; num_vec = 8'd3; res_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 0);
        chk("rst w_rd_en", 32'(w_rd_en), 0);
        chk("rst init_win", 32'(init_win), 0);
        chk("rst a_rd_en", 32'(a_rd_en), 0);
        chk("rst dv_ain", 32'(dv_ain), 0);
        chk("rst res_wr_en", 32'(res_wr_en), 0);
`ifdef MAC_ARRAY_CTRL_PERF_EN
        chk("rst perf", perf_cycles, 0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            start = tv[i].start; num_vec = tv[i].nv; res_valid = tv[i].rv;
            #1;
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tv[i].busy));
            chk($sformatf("v%0d done", i), 32'(done), 32'(tv[i].done));
            chk($sformatf("v%0d w_rd_en", i), 32'(w_rd_en), 32'(tv[i].wen));
            chk($sformatf("v%0d w_rd_addr", i), 32'(w_rd_addr), 32'(tv[i].waddr));
            chk($sformatf("v%0d init_win", i), 32'(init_win), 32'(tv[i].iw));
            chk($sformatf("v%0d a_rd_en", i), 32'(a_rd_en), 32'(tv[i].aen));
            chk($sformatf("v%0d a_rd_addr", i), 32'(a_rd_addr), 32'(tv[i].aaddr));
            chk($sformatf("v%0d dv_ain", i), 32'(dv_ain), 32'(tv[i].dv));
            chk($sformatf("v%0d res_wr_en", i), 32'(res_wr_en), 32'(tv[i].ren));
            chk($sformatf("v%0d res_wr_addr", i), 32'(res_wr_addr), 32'(tv[i].raddr));
            step();
        end
        start = 1'b0; res_valid = 1'b0;

        // Zero-length job is ignored.
        start = 1'b1; num_vec = 8'd0;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("nv0 busy c%0d", k), 32'(busy), 0);
            chk($sformatf("nv0 rd c%0d", k), 32'(w_rd_en | a_rd_en), 0);
            chk($sformatf("nv0 done c%0d", k), 32'(done), 0);
            step();
        end

        // Reset mid-STREAM, then a clean job accepted on the first edge after release.
        start = 1'b1; num_vec = 8'd3;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("pre-rst a_rd_en", 32'(a_rd_en), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 0);
        chk("midrst a_rd_en", 32'(a_rd_en), 0);
        chk("midrst dv_ain", 32'(dv_ain), 0);
        chk("midrst init_win", 32'(init_win), 0);
        start = 1'b1; num_vec = 8'd2;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start = 1'b0;
        chk("post-rst w_rd_en", 32'(w_rd_en), 1);
        chk("post-rst w_rd_addr", 32'(w_rd_addr), 3);
        repeat (4) step();
        res_valid = 1'b1;
        #1;
        chk("post-rst a_rd_addr0", 32'(a_rd_addr), 0);
        chk("post-rst wr0", 32'(res_wr_en), 1);
        chk("post-rst wa0", 32'(res_wr_addr), 0);
        step();
        chk("post-rst a_rd_addr1", 32'(a_rd_addr), 1);
        chk("post-rst wa1", 32'(res_wr_addr), 1);
        step();
        chk("drain a_rd_en", 32'(a_rd_en), 0);
        chk("excess res dropped", 32'(res_wr_en), 0);
        chk("drain busy", 32'(busy), 1);
        step();
        res_valid = 1'b0;
        chk("post-rst done", 32'(done), 1);
        step();
        chk("post-rst idle", 32'(busy), 0);

        // Maximum job length: counters must reach num_vec-1 without wrapping.
        start = 1'b1; num_vec = 8'd255;
        step();
        start = 1'b0; res_valid = 1'b1;
        na = 0; nw = 0; nd = 0; la = 0; lw = 0; fin = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            if (a_rd_en) begin na++; la = int'(a_rd_addr); end
            if (res_wr_en) begin nw++; lw = int'(res_wr_addr); end
            if (done) nd++;
            step();
            if (nd != 0 && !busy) fin = 1'b1;
        end
        res_valid = 1'b0;
        chk("max finished", 32'(fin), 1);
        chk("max reads", 32'(na), 255);
        chk("max last a_addr", 32'(la), 254);
        chk("max writes", 32'(nw), 255);
        chk("max last r_addr", 32'(lw), 254);
        chk("max done pulses", 32'(nd), 1);

`ifdef MAC_ARRAY_CTRL_PERF_EN
        // Busy-cycle counter: results on last STREAM and first DRAIN cycle.
        start = 1'b1; num_vec = 8'd2;
        step();
        start = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 12; k++) begin
            res_valid = (k == 5 || k == 6);
            #1;
            if (busy) nbusy++;
            step();
        end
        res_valid = 1'b0;
        chk("perf vs counted", perf_cycles, 32'(nbusy));
        chk("perf value", perf_cycles, 8);
        repeat (3) step();
        chk("perf hold", perf_cycles, 8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
